// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use/branch/memory-stall resolution and a memory-wait FSM.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
//
// state    | meaning
// RUN      | pipeline flowing, no outstanding data-memory wait
// MEM_WAIT | data memory access stalled, counting wait cycles toward timeout
module pipe_hazard_ctrl #(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       ResultSrcE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       PCSrcE,
   input  logic       MemAccessM,
   input  logic       dmem_ready,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       mem_wait,
   output logic       mem_timeout
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
`endif
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] WMAX = 8'(WAIT_MAX);

   state_t     state;
   state_t     state_next;
   logic [7:0] wait_cnt;
   logic       timeout_q;
   logic       timeout_hit;
   logic       mem_stall;
   logic       lw_stall;
   logic       branch;

   // Gating with rst keeps every combinational output quiet during reset.
   assign mem_stall = ~rst & MemAccessM & ~dmem_ready;
   assign lw_stall  = ~rst & ResultSrcE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
   assign branch    = ~rst & PCSrcE;

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!rst) begin
         if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
         else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
         if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
         else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
      end
   end

   // A branch held in Execute by a memory stall flushes once the stall drops.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (mem_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (branch) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lw_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:      if (mem_stall)  state_next = MEM_WAIT;
         MEM_WAIT: if (!mem_stall) state_next = RUN;
         default:  state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_next;
         timeout_q <= timeout_q | timeout_hit;
         if ((state == RUN) && mem_stall)
            wait_cnt <= 8'd0;
         else if ((state == MEM_WAIT) && mem_stall && (wait_cnt != WMAX))
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign mem_wait = (state == MEM_WAIT);

   // Timeout shows in the same cycle whose increment brings wait_cnt to WAIT_MAX.
   assign timeout_hit = mem_wait & mem_stall & (wait_cnt == (WMAX - 8'd1));
   assign mem_timeout = timeout_q | timeout_hit;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         flush_events <= 32'd0;
      end else begin
         if (StallF) stall_cycles <= stall_cycles + 32'd1;
         if (FlushE) flush_events <= flush_events + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle sequences
// and randomized stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;
   localparam int WMAX = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemAccessM, dmem_ready;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       mem_wait, mem_timeout;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   pipe_hazard_ctrl #(.WAIT_MAX(WMAX)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mem_wait(mem_wait), .mem_timeout(mem_timeout)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rsrce, rwm, rww, pcsrc, macc, rdy;
   } vin_t;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic       sf, sd, se, sm, fd, fe, fw, mw, mt;
   } vout_t;

   typedef struct {
      string name;
      vin_t  i;
      vout_t o;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   m_run;   // consecutive memory-stall cycles seen before the current cycle
   logic m_to;
   int   m_sc, m_fc;

   function automatic logic [1:0] fwd(logic [4:0] rs, logic [4:0] rdm, logic wm,
                                      logic [4:0] rdw, logic ww);
      if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
      if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   // The wait state is simply "the previous cycle was a memory stall"; timeout is
   // reached once WMAX stalled cycles have been spent in the wait state.
   function automatic vout_t model(vin_t v);
      vout_t o;
      logic  ms, lw;
      o  = '0;
      ms = v.macc && !v.rdy;
      lw = v.rsrce && v.rde != 5'd0 && (v.rde == v.rs1d || v.rde == v.rs2d);
      o.fa = fwd(v.rs1e, v.rdm, v.rwm, v.rdw, v.rww);
      o.fb = fwd(v.rs2e, v.rdm, v.rwm, v.rdw, v.rww);
      if (ms) begin
         o.sf = 1'b1; o.sd = 1'b1; o.se = 1'b1; o.sm = 1'b1; o.fw = 1'b1;
      end else if (v.pcsrc) begin
         o.fd = 1'b1; o.fe = 1'b1;
      end else if (lw) begin
         o.sf = 1'b1; o.sd = 1'b1; o.fe = 1'b1;
      end
      o.mw = (m_run > 0);
      o.mt = m_to || (ms && m_run >= WMAX);
      return o;
   endfunction

   function automatic vout_t sample();
      vout_t o;
      o = '{fa:ForwardAE, fb:ForwardBE, sf:StallF, sd:StallD, se:StallE, sm:StallM,
            fd:FlushD, fe:FlushE, fw:FlushW, mw:mem_wait, mt:mem_timeout};
      return o;
   endfunction

   task automatic drive(input vin_t v);
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
      RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
      ResultSrcE = v.rsrce; RegWriteM = v.rwm; RegWriteW = v.rww;
      PCSrcE = v.pcsrc; MemAccessM = v.macc; dmem_ready = v.rdy;
   endtask

   task automatic check(input string name, input vout_t got, input vout_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic cycle(input string name, input vin_t v, input bit use_tbl,
                        input vout_t tbl_exp, output vout_t got);
      vout_t m, e;
      m = '0;
      drive(v);
      m = model(v);
      e = use_tbl ? tbl_exp : m;
      @(negedge clk);
      got = sample();
      check(name, got, e);
      m_sc += int'(m.sf);
      m_fc += int'(m.fe);
      m_to  = m.mt;
      m_run = (v.macc && !v.rdy) ? m_run + 1 : 0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive('0);
      @(negedge clk);
      check("reset_outputs", sample(), '0);
`ifdef HAZ_PERF_CNT_EN
      check_val("reset_stall_cycles", stall_cycles, 32'd0);
      check_val("reset_flush_events", flush_events, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_run = 0; m_to = 1'b0; m_sc = 0; m_fc = 0;
   endtask

   vec_t  tbl[$];
   vout_t got;
   vin_t  v;
   vin_t  stl, rdy_v;
   logic  exp_mt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      rst = 1'b1;
      drive('0);

      tbl.push_back('{"fwd_a_mem",  '{rdm:5, rwm:1, rdw:5, rww:1, rs1e:5, default:0}, '{fa:2'b10, default:0}});
      tbl.push_back('{"fwd_a_wb",   '{rdm:5, rdw:5, rww:1, rs1e:5, default:0},         '{fa:2'b01, default:0}});
      tbl.push_back('{"fwd_a_r0",   '{rwm:1, rww:1, rs1e:5, default:0},                '{default:0}});
      tbl.push_back('{"fwd_b_mem",  '{rdm:3, rwm:1, rs2e:3, default:0},                '{fb:2'b10, default:0}});
      tbl.push_back('{"fwd_b_wb",   '{rdm:9, rdw:9, rww:1, rs2e:9, default:0},         '{fb:2'b01, default:0}});
      tbl.push_back('{"fwd_both",   '{rdm:4, rwm:1, rdw:6, rww:1, rs1e:6, rs2e:4, default:0},
                                    '{fa:2'b01, fb:2'b10, default:0}});
      tbl.push_back('{"fwd_w_r0",   '{rww:1, default:0},                               '{default:0}});
      tbl.push_back('{"lw_rs2",     '{rsrce:1, rde:7, rs2d:7, default:0},              '{sf:1, sd:1, fe:1, default:0}});
      tbl.push_back('{"lw_rd0",     '{rsrce:1, default:0},                             '{default:0}});
      tbl.push_back('{"lw_rs1",     '{rsrce:1, rde:12, rs1d:12, default:0},            '{sf:1, sd:1, fe:1, default:0}});
      tbl.push_back('{"lw_noload",  '{rde:7, rs1d:7, default:0},                       '{default:0}});
      tbl.push_back('{"lw_branch",  '{rsrce:1, rde:7, rs2d:7, pcsrc:1, default:0},     '{fd:1, fe:1, default:0}});
      tbl.push_back('{"branch",     '{pcsrc:1, default:0},                             '{fd:1, fe:1, default:0}});
      tbl.push_back('{"idle",       '{default:0},                                      '{default:0}});

      do_reset();
      foreach (tbl[k]) cycle(tbl[k].name, tbl[k].i, 1'b1, tbl[k].o, got);

      // Load-use + branch, then a three-cycle memory stall.
      do_reset();
      cycle("lw_branch_seq", '{rsrce:1, rde:7, rs2d:7, pcsrc:1, default:0}, 1'b0, '0, got);
      stl   = '{macc:1, rdy:0, default:0};
      rdy_v = '{macc:1, rdy:1, default:0};
      for (int c = 1; c <= 5; c++) begin
         cycle("memwait_seq", (c <= 3) ? stl : ((c == 4) ? rdy_v : vin_t'('0)), 1'b0, '0, got);
         check_val("memwait_stall", 32'(got.sf & got.fw), (c <= 3) ? 32'd1 : 32'd0);
         check_val("memwait_state", 32'(got.mw), (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
      end
`ifdef HAZ_PERF_CNT_EN
      check_val("perf_flush_events", flush_events, 32'd1);
      check_val("perf_stall_cycles", stall_cycles, 32'd3);
`endif

      // Branch held behind a memory stall flushes when the stall drops.
      do_reset();
      v = '{macc:1, rdy:0, pcsrc:1, default:0};
      cycle("held_branch_stall", v, 1'b0, '0, got);
      cycle("held_branch_stall", v, 1'b0, '0, got);
      v.rdy = 1'b1;
      cycle("held_branch_release", v, 1'b0, '0, got);
      check_val("held_branch_flush", 32'({got.fd, got.fe, got.sf}), 32'b110);

      // Timeout on the WMAX-th wait cycle, then an asynchronous reset mid-cycle.
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cycle("timeout_seq", stl, 1'b0, '0, got);
         check_val("timeout_flag", 32'(got.mt), 32'(exp_mt[c]));
      end
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", sample(), '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_run = 0; m_to = 1'b0; m_sc = 0; m_fc = 0;
      cycle("after_async_reset", stl, 1'b0, '0, got);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         v.rs1d  = 5'($urandom_range(0, 3));
         v.rs2d  = 5'($urandom_range(0, 3));
         v.rs1e  = 5'($urandom_range(0, 3));
         v.rs2e  = 5'($urandom_range(0, 3));
         v.rde   = 5'($urandom_range(0, 3));
         v.rdm   = 5'($urandom_range(0, 3));
         v.rdw   = 5'($urandom_range(0, 3));
         v.rsrce = 1'($urandom_range(0, 1));
         v.rwm   = 1'($urandom_range(0, 1));
         v.rww   = 1'($urandom_range(0, 1));
         v.pcsrc = ($urandom_range(0, 3) == 0);
         v.macc  = ($urandom_range(0, 2) != 0);
         v.rdy   = ($urandom_range(0, 3) == 0);
         cycle("random", v, 1'b0, '0, got);
      end
`ifdef HAZ_PERF_CNT_EN
      check_val("rand_stall_cycles", stall_cycles, 32'(m_sc));
      check_val("rand_flush_events", flush_events, 32'(m_fc));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
